k502_linebuf_ctrl: RTL and testbench

Sequencer for the sprite line-buffer pair behind the 502 pixel mixer. Two external single-port RAMs (bank A, bank B) alternate roles every line. One bank is the draw bank, written by the sprite renderer. The other is the display bank, read out pixel by pixel and cleared behind the beam. The block owns the bank swap, both address/write-enable sets, clear-after-read and the renderer write handshake. It presents a registered colour code and a zero flag to the mixer.

---
 rtl/k502_linebuf_ctrl.sv | 131 +++++++++++++
 tb/tb_k502_linebuf_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k502_linebuf_ctrl.sv
// Line-buffer pair sequencer for the 502 mixer: bank swap, display read/clear-behind-beam,
// and the renderer write port into the draw bank.
module k502_linebuf_ctrl #(
  parameter int ADDR_W = 8,
  parameter int PIX_W  = 4
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              pix_en,
  input  logic              line_active,
  input  logic              swap,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_x,
  input  logic [PIX_W-1:0]  wr_pix,
  output logic              wr_ack,
  output logic              bank_sel,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              a_we,
  output logic              b_we,
  output logic [PIX_W-1:0]  a_wdata,
  output logic [PIX_W-1:0]  b_wdata,
  input  logic [PIX_W-1:0]  a_rdata,
  input  logic [PIX_W-1:0]  b_rdata,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_zero,
  output logic [1:0]        dbg_state  // 0 IDLE, 1 READ, 2 CLEAR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] x_cnt, x_cnt_d;
  logic              swap_pend, swap_pend_d;
  logic              swap_take;
  logic              bank_sel_d;
  logic [PIX_W-1:0]  pix_out_d;
  logic [PIX_W-1:0]  disp_rdata;
  logic              disp_we;

  logic              wr_take;
  logic [ADDR_W-1:0] wr_x_q;
  logic [PIX_W-1:0]  wr_pix_q;
  logic [ADDR_W-1:0] draw_addr;
  logic              draw_we;
  logic [PIX_W-1:0]  draw_wdata;

  assign disp_rdata = bank_sel ? b_rdata : a_rdata;

  // Display FSM. The address sits on x_cnt in every state, so the read issued in IDLE
  // returns data during READ, which is also the cycle the location is zeroed.
  always_comb begin
    state_d     = state;
    x_cnt_d     = x_cnt;
    swap_pend_d = swap_pend;
    bank_sel_d  = bank_sel;
    pix_out_d   = pix_out;
    swap_take   = 1'b0;
    disp_we     = 1'b0;
    case (state)
      IDLE: begin
        // A swap landing with a pixel strobe wins: the bank flips and the strobe is dropped.
        swap_take = swap;
        if (!swap && pix_en && line_active) state_d = READ;
      end
      READ: begin
        disp_we   = 1'b1;
        pix_out_d = disp_rdata;
        state_d   = CLEAR;
        if (swap) swap_pend_d = 1'b1;
      end
      CLEAR: begin
        state_d   = IDLE;
        swap_take = swap | swap_pend;
        x_cnt_d   = x_cnt + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (swap_take) begin
      bank_sel_d  = ~bank_sel;
      x_cnt_d     = '0;
      swap_pend_d = 1'b0;
    end
  end

  // Renderer port: wr_req is a held valid and wr_ack a one-cycle ready/accept pulse. A request
  // is accepted when no ack is already out and no swap lands this edge; the write is issued to
  // the draw bank in the ack cycle from the captured address/pixel, skipped when the pixel is 0.
  assign wr_take    = wr_req & ~wr_ack & ~swap_take;
  assign draw_addr  = wr_ack ? wr_x_q : '0;
  assign draw_we    = wr_ack & (wr_pix_q != '0);
  assign draw_wdata = wr_ack ? wr_pix_q : '0;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state     <= IDLE;
      x_cnt     <= '0;
      swap_pend <= 1'b0;
      bank_sel  <= 1'b0;
      pix_out   <= '0;
      wr_ack    <= 1'b0;
      wr_x_q    <= '0;
      wr_pix_q  <= '0;
    end else begin
      state     <= state_d;
      x_cnt     <= x_cnt_d;
      swap_pend <= swap_pend_d;
      bank_sel  <= bank_sel_d;
      pix_out   <= pix_out_d;
      wr_ack    <= wr_take;
      if (wr_take) begin
        wr_x_q   <= wr_x;
        wr_pix_q <= wr_pix;
      end
    end
  end

  assign a_addr    = bank_sel ? draw_addr  : x_cnt;
  assign a_we      = bank_sel ? draw_we    : disp_we;
  assign a_wdata   = bank_sel ? draw_wdata : '0;
  assign b_addr    = bank_sel ? x_cnt      : draw_addr;
  assign b_we      = bank_sel ? disp_we    : draw_we;
  assign b_wdata   = bank_sel ? '0         : draw_wdata;
  assign pix_zero  = (pix_out == '0);
  assign dbg_state = state;

endmodule

// File: tb/tb_k502_linebuf_ctrl.sv
// Bench for k502_linebuf_ctrl: RAM models for both banks, a timestamp-based reference model
// compared every cycle, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_k502_linebuf_ctrl;
  localparam int ADDR_W = 8;
  localparam int PIX_W  = 4;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              nReset = 1'b0;
  logic              pix_en = 1'b0;
  logic              line_active = 1'b0;
  logic              swap = 1'b0;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_x = '0;
  logic [PIX_W-1:0]  wr_pix = '0;
  logic              wr_ack, bank_sel, a_we, b_we, pix_zero;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [PIX_W-1:0]  a_wdata, b_wdata, pix_out;
  logic [PIX_W-1:0]  a_rdata = '0;
  logic [PIX_W-1:0]  b_rdata = '0;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  logic [PIX_W-1:0] exp_q[$];

  k502_linebuf_ctrl #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
    .clk(clk), .nReset(nReset), .pix_en(pix_en), .line_active(line_active), .swap(swap),
    .wr_req(wr_req), .wr_x(wr_x), .wr_pix(wr_pix), .wr_ack(wr_ack), .bank_sel(bank_sel),
    .a_addr(a_addr), .b_addr(b_addr), .a_we(a_we), .b_we(b_we), .a_wdata(a_wdata),
    .b_wdata(b_wdata), .a_rdata(a_rdata), .b_rdata(b_rdata), .pix_out(pix_out),
    .pix_zero(pix_zero), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic [PIX_W-1:0] init_a(input int i);
    if (i < 3) return '0;
    if (i == 3) return 4'd5;
    return 4'((i * 7 + 3) % 16);
  endfunction

  function automatic logic [PIX_W-1:0] init_b(input int i);
    return 4'((i * 5 + 1) % 16);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- external RAMs ----------------
  logic [PIX_W-1:0] ram_a [DEPTH];
  logic [PIX_W-1:0] ram_b [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_a[i] = init_a(i);
      ram_b[i] = init_b(i);
    end
    forever begin
      @(posedge clk);
      if (a_we === 1'b1) ram_a[a_addr] <= a_wdata;
      if (b_we === 1'b1) ram_b[b_addr] <= b_wdata;
      a_rdata <= ram_a[a_addr];
      b_rdata <= ram_b[b_addr];
    end
  end

  // ---------------- reference model ----------------
  // Each pixel is a timestamp: read_cyc is the edge that accepted it; the cycle after it is
  // the read/clear cycle, the one after that finishes the pixel. Contents tracked per bank.
  int               cyc = 0;
  int               read_cyc = -100;
  int               ack_cyc = -100;
  logic             m_valid = 1'b0;
  logic             m_bank, m_swap_wait;
  logic [ADDR_W-1:0] m_x, m_ack_x;
  logic [PIX_W-1:0]  m_pix, m_ack_pix;
  logic [PIX_W-1:0]  exp_a [DEPTH];
  logic [PIX_W-1:0]  exp_b [DEPTH];

  initial begin
    logic was_read, was_clear, was_idle, do_swap, take;
    for (int i = 0; i < DEPTH; i++) begin
      exp_a[i] = init_a(i);
      exp_b[i] = init_b(i);
    end
    forever begin
      @(posedge clk);
      cyc++;
      if (!nReset) begin
        m_valid = 1'b1; m_bank = 1'b0; m_swap_wait = 1'b0; m_x = '0; m_pix = '0;
        m_ack_x = '0; m_ack_pix = '0; read_cyc = -100; ack_cyc = -100;
      end else if (m_valid) begin
        was_read  = (read_cyc == cyc - 1);
        was_clear = (read_cyc == cyc - 2);
        was_idle  = !was_read && !was_clear;
        do_swap   = was_idle ? swap : (was_clear && (swap || m_swap_wait));
        if (pix_en) chk("pix_spacing", 32'(was_idle), 32'd1);
        if (was_read) begin
          if (m_bank == 1'b0) begin m_pix = exp_a[m_x]; exp_a[m_x] = '0; end
          else begin m_pix = exp_b[m_x]; exp_b[m_x] = '0; end
        end
        if (was_read && swap) m_swap_wait = 1'b1;
        take = wr_req && (ack_cyc != cyc - 1) && !do_swap;
        if (do_swap) begin
          m_bank = ~m_bank; m_x = '0; m_swap_wait = 1'b0;
        end else if (was_clear) begin
          m_x = m_x + 1'b1;
        end
        if (was_idle && pix_en && line_active && !do_swap) read_cyc = cyc;
        if (take) begin
          ack_cyc = cyc; m_ack_x = wr_x; m_ack_pix = wr_pix;
          if (wr_pix != '0) begin
            if (m_bank == 1'b0) exp_b[wr_x] = wr_pix; else exp_a[wr_x] = wr_pix;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic e_read, e_ack, d_we, ea_we, eb_we;
    logic [1:0] e_state;
    logic [ADDR_W-1:0] d_addr, ea_addr, eb_addr;
    logic [PIX_W-1:0] d_wdata, ea_wdata, eb_wdata;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        e_read  = (read_cyc == cyc);
        e_state = e_read ? 2'd1 : ((read_cyc == cyc - 1) ? 2'd2 : 2'd0);
        e_ack   = (ack_cyc == cyc);
        d_addr  = e_ack ? m_ack_x : '0;
        d_we    = e_ack && (m_ack_pix != '0);
        d_wdata = e_ack ? m_ack_pix : '0;
        if (m_bank == 1'b0) begin
          ea_addr = m_x; ea_we = e_read; ea_wdata = '0;
          eb_addr = d_addr; eb_we = d_we; eb_wdata = d_wdata;
        end else begin
          eb_addr = m_x; eb_we = e_read; eb_wdata = '0;
          ea_addr = d_addr; ea_we = d_we; ea_wdata = d_wdata;
        end
        chk("bank_sel", 32'(bank_sel), 32'(m_bank));
        chk("wr_ack", 32'(wr_ack), 32'(e_ack));
        chk("a_addr", 32'(a_addr), 32'(ea_addr));
        chk("a_we", 32'(a_we), 32'(ea_we));
        chk("a_wdata", 32'(a_wdata), 32'(ea_wdata));
        chk("b_addr", 32'(b_addr), 32'(eb_addr));
        chk("b_we", 32'(b_we), 32'(eb_we));
        chk("b_wdata", 32'(b_wdata), 32'(eb_wdata));
        chk("pix_out", 32'(pix_out), 32'(m_pix));
        chk("pix_zero", 32'(pix_zero), 32'(m_pix == '0));
        chk("state", 32'(dbg_state), 32'(e_state));
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic              obs_a_we, obs_b_we;
  logic [ADDR_W-1:0] obs_a_addr, obs_b_addr;
  logic [PIX_W-1:0]  obs_a_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pixel: strobe cycle, read/clear cycle (observed), finishing cycle. Returns with
  // pix_out already updated; swap is driven during the read and finishing cycles as asked.
  task automatic pixel(input logic sw_read, input logic sw_clear);
    tick(); pix_en = 1'b1;
    tick(); pix_en = 1'b0; swap = sw_read;
    obs_a_we = a_we; obs_a_addr = a_addr; obs_a_wdata = a_wdata;
    obs_b_we = b_we; obs_b_addr = b_addr;
    tick(); swap = sw_clear;
  endtask

  task automatic write(input logic [ADDR_W-1:0] x, input logic [PIX_W-1:0] p);
    tick(); wr_req = 1'b1; wr_x = x; wr_pix = p;
    tick(); wr_req = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [PIX_W-1:0] e;
    exp_q.push_back(4'h0); exp_q.push_back(4'h0); exp_q.push_back(4'h0); exp_q.push_back(4'h5);

    repeat (3) tick();
    nReset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_wr_ack", 32'(wr_ack), 32'd0);
    end
    chk("rst_bank_sel", 32'(bank_sel), 32'd0);
    chk("rst_pix_zero", 32'(pix_zero), 32'd1);
    chk("rst_we", 32'({a_we, b_we}), 32'd0);

    // four pixels from bank A; location 3 holds 5
    line_active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pixel(1'b0, 1'b0);
      chk("clr_a_we", 32'(obs_a_we), 32'd1);
      chk("clr_a_addr", 32'(obs_a_addr), 32'(i));
      chk("clr_a_wdata", 32'(obs_a_wdata), 32'd0);
      e = exp_q.pop_front();
      chk("pix_seq", 32'(pix_out), 32'(e));
      chk("pix_zero_seq", 32'(pix_zero), 32'(e == '0));
    end

    // strobe outside the display window is ignored
    line_active = 1'b0;
    tick(); pix_en = 1'b1;
    tick(); pix_en = 1'b0;
    chk("inactive_we", 32'({a_we, b_we}), 32'd0);
    chk("inactive_state", 32'(dbg_state), 32'd0);
    line_active = 1'b1;

    // renderer writes into bank B
    tick(); wr_req = 1'b1; wr_x = 8'h10; wr_pix = 4'h7;
    tick(); wr_req = 1'b0;
    chk("wr_ack", 32'(wr_ack), 32'd1);
    chk("wr_b_addr", 32'(b_addr), 32'h10);
    chk("wr_b_we", 32'(b_we), 32'd1);
    chk("wr_b_wdata", 32'(b_wdata), 32'h7);
    tick(); wr_req = 1'b1; wr_x = 8'h11; wr_pix = 4'h0;
    tick(); wr_req = 1'b0;
    chk("skip_ack", 32'(wr_ack), 32'd1);
    chk("skip_b_we", 32'(b_we), 32'd0);

    // swap in READ and again in CLEAR: clear still on A at x=4, one toggle
    pixel(1'b1, 1'b1);
    chk("swap_clr_a_we", 32'(obs_a_we), 32'd1);
    chk("swap_clr_a_addr", 32'(obs_a_addr), 32'd4);
    chk("swap_held", 32'(bank_sel), 32'd0);
    tick(); swap = 1'b0;
    chk("swap_toggle", 32'(bank_sel), 32'd1);
    chk("swap_x_clear", 32'(b_addr), 32'd0);
    chk("swap_idle", 32'(dbg_state), 32'd0);
    tick(); tick();
    chk("swap_single", 32'(bank_sel), 32'd1);

    // idle swap back to 0, then a request held across a swap edge
    tick(); swap = 1'b1;
    tick(); swap = 1'b0;
    chk("idle_swap", 32'(bank_sel), 32'd0);
    tick(); swap = 1'b1; wr_req = 1'b1; wr_x = 8'h20; wr_pix = 4'h9;
    tick(); swap = 1'b0;
    chk("swap_no_ack", 32'(wr_ack), 32'd0);
    chk("swap_to_1", 32'(bank_sel), 32'd1);
    tick(); wr_req = 1'b0;
    chk("post_swap_ack", 32'(wr_ack), 32'd1);
    chk("post_swap_a_addr", 32'(a_addr), 32'h20);
    chk("post_swap_a_we", 32'(a_we), 32'd1);
    chk("post_swap_a_wdata", 32'(a_wdata), 32'h9);
    tick();
    chk("ack_one_cycle", 32'(wr_ack), 32'd0);

    // full line from bank B, then wrap
    for (int i = 0; i < DEPTH; i++) begin
      pixel(1'b0, 1'b0);
      if (i == 16) chk("line_written_px", 32'(pix_out), 32'h7);
      if (i == 17) chk("line_skipped_px", 32'(pix_out), 32'(init_b(17)));
    end
    pixel(1'b0, 1'b0);
    chk("wrap_b_addr", 32'(obs_b_addr), 32'd0);
    chk("wrap_b_we", 32'(obs_b_we), 32'd1);
    chk("wrap_cleared_px", 32'(pix_out), 32'd0);

    // reset during the finishing cycle of a pixel
    tick(); pix_en = 1'b1;
    tick(); pix_en = 1'b0;
    tick(); nReset = 1'b0;
    tick();
    chk("mid_rst_we", 32'({a_we, b_we}), 32'd0);
    chk("mid_rst_bank", 32'(bank_sel), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'd0);
    chk("mid_rst_pix_zero", 32'(pix_zero), 32'd1);
    nReset = 1'b1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
